// File: rtl/sprite_pixel_drawer.sv
// Paints a SPRITE_W x SPRITE_H block into the VGA frame buffer one pixel per clock,
// either restoring background ROM pixels or copying non-transparent sprite ROM pixels.
module sprite_pixel_drawer #(
  parameter int                     SPRITE_W    = 8,
  parameter int                     SPRITE_H    = 8,
  parameter int                     SPRITE_AW   = 6,
  parameter int                     COLOUR_W    = 9,
  parameter logic [COLOUR_W-1:0]    TRANSPARENT = 9'h1FF
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 drawBG,
  input  logic                 drawChar,
  input  logic [8:0]           xCoordinate,
  input  logic [7:0]           yCoordinate,
  input  logic [COLOUR_W-1:0]  spriteColour,
  input  logic [COLOUR_W-1:0]  bgColour,
  output logic [SPRITE_AW-1:0] spriteAddr,
  output logic [16:0]          bgAddr,
  output logic [8:0]           vgaX,
  output logic [7:0]           vgaY,
  output logic [COLOUR_W-1:0]  vgaColour,
  output logic                 plot,
  output logic                 doneBG,
  output logic                 doneChar
);

  localparam int CXW = (SPRITE_W > 1) ? $clog2(SPRITE_W) : 1;
  localparam int CYW = (SPRITE_H > 1) ? $clog2(SPRITE_H) : 1;

  typedef enum logic [2:0] {IDLE, LOAD, RUN, FLUSH, DONE} state_t;

  state_t         state;
  logic [8:0]     base_x;
  logic [7:0]     base_y;
  logic [CXW-1:0] cx;
  logic [CYW-1:0] cy;
  logic           mode_bg;
  logic [9:0]     px, stage_px;
  logic [8:0]     py, stage_py;
  logic           stage_valid;
  logic           last_pixel;
  logic           on_screen;

  // Wide sums so pixels past the screen edge are clipped instead of wrapping.
  assign px         = {1'b0, base_x} + 10'(cx);
  assign py         = {1'b0, base_y} + 9'(cy);
  assign bgAddr     = 17'(py) * 17'd320 + 17'(px);
  assign spriteAddr = SPRITE_AW'(cy) * SPRITE_AW'(SPRITE_W) + SPRITE_AW'(cx);
  assign last_pixel = (cx == CXW'(SPRITE_W - 1)) && (cy == CYW'(SPRITE_H - 1));

  // The pipeline stage lines up with the ROM data returned for the same pixel.
  assign on_screen = (stage_px < 10'd320) && (stage_py < 9'd240);
  assign vgaX      = stage_px[8:0];
  assign vgaY      = stage_py[7:0];
  assign vgaColour = stage_valid ? (mode_bg ? bgColour : spriteColour) : '0;
  assign plot      = stage_valid && on_screen && (mode_bg || spriteColour != TRANSPARENT);

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      base_x      <= '0;
      base_y      <= '0;
      cx          <= '0;
      cy          <= '0;
      mode_bg     <= 1'b0;
      stage_px    <= '0;
      stage_py    <= '0;
      stage_valid <= 1'b0;
      doneBG      <= 1'b0;
      doneChar    <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      stage_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (drawBG || drawChar) begin
            mode_bg <= drawBG;
            state   <= LOAD;
          end
        end
        LOAD: begin
          base_x <= xCoordinate;
          base_y <= yCoordinate;
          cx     <= '0;
          cy     <= '0;
          state  <= RUN;
        end
        RUN: begin
          stage_valid <= 1'b1;
          stage_px    <= px;
          stage_py    <= py;
          if (cx == CXW'(SPRITE_W - 1)) begin
            cx <= '0;
            cy <= cy + CYW'(1);
          end else begin
            cx <= cx + CXW'(1);
          end
          if (last_pixel) state <= FLUSH;
        end
        FLUSH: begin
          doneBG   <= mode_bg;
          doneChar <= !mode_bg;
          state    <= DONE;
        end
        DONE: begin
          // Hold done until the request drops so a held level cannot retrigger.
          if (!(mode_bg ? drawBG : drawChar)) begin
            doneBG   <= 1'b0;
            doneChar <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sprite_pixel_drawer.sv
// Directed testbench for sprite_pixel_drawer with synchronous ROM models and a
// frame-buffer monitor that records every plotted pixel.
module tb_sprite_pixel_drawer;

  localparam logic [8:0] TRANSP = 9'h1FF;

  logic       clock = 1'b0;
  logic       reset;
  logic       drawBG, drawChar;
  logic [8:0] xCoordinate;
  logic [7:0] yCoordinate;
  logic [8:0] spriteColour, bgColour;
  logic [5:0] spriteAddr;
  logic [16:0] bgAddr;
  logic [8:0] vgaX;
  logic [7:0] vgaY;
  logic [8:0] vgaColour;
  logic       plot, doneBG, doneChar;

  typedef struct packed {
    logic [8:0] x;
    logic [7:0] y;
    logic [8:0] c;
  } pix_t;

  pix_t got[$];
  pix_t exp_q[$];
  int   checks = 0;
  int   passed = 0;

  sprite_pixel_drawer dut (
    .clock(clock), .reset(reset), .drawBG(drawBG), .drawChar(drawChar),
    .xCoordinate(xCoordinate), .yCoordinate(yCoordinate),
    .spriteColour(spriteColour), .bgColour(bgColour),
    .spriteAddr(spriteAddr), .bgAddr(bgAddr),
    .vgaX(vgaX), .vgaY(vgaY), .vgaColour(vgaColour),
    .plot(plot), .doneBG(doneBG), .doneChar(doneChar)
  );

  always #5 clock = ~clock;

  // Sprite ROM: first row transparent, other entries tagged with their address.
  function automatic logic [8:0] spr_rom(input logic [5:0] a);
    return (a < 6'd8) ? TRANSP : {3'b101, a};
  endfunction

  always @(posedge clock) begin
    spriteColour <= spr_rom(spriteAddr);
    bgColour     <= bgAddr[8:0];
  end

  always @(negedge clock) begin
    if (plot) got.push_back({vgaX, vgaY, vgaColour});
  end

  task automatic build_exp(input bit bg, input int x, input int y);
    exp_q.delete();
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 8; c++) begin
        int px, py;
        logic [8:0] col;
        px = x + c;
        py = y + r;
        if (px < 320 && py < 240) begin
          col = bg ? 9'((py * 320 + px) % 512) : spr_rom(6'(r * 8 + c));
          if (bg || col != TRANSP) exp_q.push_back({9'(px), 8'(py), col});
        end
      end
    end
  endtask

  // Index of the first differing plot, or -1 when recorded and expected lists agree.
  function automatic int plot_diff();
    int n;
    n = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
    for (int i = 0; i < n; i++) if (got[i] !== exp_q[i]) return i;
    if (got.size() != exp_q.size()) return n;
    return -1;
  endfunction

  task automatic start(input bit bg, input bit ch, input int x, input int y);
    @(posedge clock); #1;
    xCoordinate = 9'(x);
    yCoordinate = 8'(y);
    drawBG      = bg;
    drawChar    = ch;
  endtask

  // Counts edges from the next posedge until the selected done flag is seen (-1 on timeout).
  task automatic wait_done(input bit bg, output int edge_n);
    edge_n = -1;
    for (int n = 0; n < 200; n++) begin
      @(posedge clock); #1;
      if (bg ? doneBG : doneChar) begin
        edge_n = n;
        return;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; drawBG = 1'b0; drawChar = 1'b0;
    xCoordinate = '0; yCoordinate = '0;
    repeat (2) @(posedge clock);
    #1;
    checks++; if (plot !== 1'b0) $display("FAIL reset plot: got %b want 0", plot); else passed++;
    checks++; if (doneBG !== 1'b0) $display("FAIL reset doneBG: got %b want 0", doneBG); else passed++;
    checks++; if (doneChar !== 1'b0) $display("FAIL reset doneChar: got %b want 0", doneChar); else passed++;
    checks++; if (vgaX !== 9'd0 || vgaY !== 8'd0) $display("FAIL reset vga xy: got %0d,%0d want 0,0", vgaX, vgaY); else passed++;
    checks++; if (vgaColour !== 9'd0) $display("FAIL reset vgaColour: got %h want 0", vgaColour); else passed++;
    checks++; if (spriteAddr !== 6'd0) $display("FAIL reset spriteAddr: got %0d want 0", spriteAddr); else passed++;
    checks++; if (bgAddr !== 17'd0) $display("FAIL reset bgAddr: got %0d want 0", bgAddr); else passed++;
    reset = 1'b0;
  endtask

  task automatic test_bg_pass();
    int e, d;
    got.delete();
    build_exp(1'b1, 95, 221);
    start(1'b1, 1'b0, 95, 221);
    wait_done(1'b1, e);
    checks++; if (e !== 66) $display("FAIL bg done latency: got edge %0d want 66", e); else passed++;
    d = plot_diff();
    checks++; if (d != -1) $display("FAIL bg plots: got %0d plots want %0d, first difference at %0d", got.size(), exp_q.size(), d); else passed++;
    checks++; if (doneChar !== 1'b0) $display("FAIL bg doneChar: got %b want 0", doneChar); else passed++;
    repeat (5) @(posedge clock);
    #1;
    checks++; if (doneBG !== 1'b1) $display("FAIL bg done hold: got %b want 1", doneBG); else passed++;
    checks++; if (got.size() != 64) $display("FAIL bg no retrigger: got %0d plots want 64", got.size()); else passed++;
    drawBG = 1'b0;
    @(posedge clock); #1;
    checks++; if (doneBG !== 1'b0) $display("FAIL bg done release: got %b want 0", doneBG); else passed++;
  endtask

  task automatic test_char_pass();
    int e, d;
    got.delete();
    build_exp(1'b0, 100, 50);
    start(1'b0, 1'b1, 100, 50);
    wait_done(1'b0, e);
    checks++; if (e !== 66) $display("FAIL char done latency: got edge %0d want 66", e); else passed++;
    d = plot_diff();
    checks++; if (d != -1) $display("FAIL char plots: got %0d plots want %0d, first difference at %0d", got.size(), exp_q.size(), d); else passed++;
    checks++; if (got.size() != 56) $display("FAIL char plot count: got %0d want 56", got.size()); else passed++;
    checks++;
    if (got.size() == 0 || got[0].x !== 9'd100 || got[0].y !== 8'd51)
      $display("FAIL char first plot: got (%0d,%0d) want (100,51)", (got.size() > 0) ? got[0].x : 9'd0, (got.size() > 0) ? got[0].y : 8'd0);
    else passed++;
    checks++; if (doneBG !== 1'b0) $display("FAIL char doneBG: got %b want 0", doneBG); else passed++;
    drawChar = 1'b0;
    @(posedge clock); #1;
    checks++; if (doneChar !== 1'b0) $display("FAIL char done release: got %b want 0", doneChar); else passed++;
  endtask

  task automatic test_both_requests();
    int e, d;
    got.delete();
    build_exp(1'b1, 10, 10);
    start(1'b1, 1'b1, 10, 10);
    wait_done(1'b1, e);
    checks++; if (e !== 66) $display("FAIL both bg latency: got edge %0d want 66", e); else passed++;
    checks++; if (doneChar !== 1'b0) $display("FAIL both doneChar early: got %b want 0", doneChar); else passed++;
    d = plot_diff();
    checks++; if (d != -1) $display("FAIL both bg plots: got %0d plots want %0d, first difference at %0d", got.size(), exp_q.size(), d); else passed++;
    drawBG = 1'b0;
    got.delete();
    build_exp(1'b0, 10, 10);
    wait_done(1'b0, e);
    checks++; if (e !== 67) $display("FAIL both char latency: got edge %0d want 67", e); else passed++;
    d = plot_diff();
    checks++; if (d != -1) $display("FAIL both char plots: got %0d plots want %0d, first difference at %0d", got.size(), exp_q.size(), d); else passed++;
    drawChar = 1'b0;
    @(posedge clock); #1;
    checks++; if (doneChar !== 1'b0) $display("FAIL both char release: got %b want 0", doneChar); else passed++;
  endtask

  task automatic test_clip_edge();
    int e, d;
    got.delete();
    build_exp(1'b1, 316, 236);
    start(1'b1, 1'b0, 316, 236);
    wait_done(1'b1, e);
    checks++; if (e !== 66) $display("FAIL clip latency: got edge %0d want 66", e); else passed++;
    checks++; if (got.size() != 16) $display("FAIL clip plot count: got %0d want 16", got.size()); else passed++;
    d = plot_diff();
    checks++; if (d != -1) $display("FAIL clip plots: got %0d plots want %0d, first difference at %0d", got.size(), exp_q.size(), d); else passed++;
    drawBG = 1'b0;
    @(posedge clock); #1;
  endtask

  task automatic test_park_position();
    int e;
    got.delete();
    start(1'b0, 1'b1, 320, 240);
    wait_done(1'b0, e);
    checks++; if (e !== 66) $display("FAIL park latency: got edge %0d want 66", e); else passed++;
    checks++; if (got.size() != 0) $display("FAIL park plot count: got %0d want 0", got.size()); else passed++;
    drawChar = 1'b0;
    @(posedge clock); #1;
    checks++; if (doneChar !== 1'b0) $display("FAIL park done release: got %b want 0", doneChar); else passed++;
  endtask

  task automatic test_reset_mid_draw();
    int e, d;
    got.delete();
    start(1'b1, 1'b0, 40, 40);
    repeat (22) @(posedge clock);
    #1;
    reset  = 1'b1;
    drawBG = 1'b0;
    @(posedge clock); #1;
    checks++; if (plot !== 1'b0) $display("FAIL midreset plot: got %b want 0", plot); else passed++;
    checks++; if (doneBG !== 1'b0) $display("FAIL midreset doneBG: got %b want 0", doneBG); else passed++;
    reset = 1'b0;
    repeat (4) @(posedge clock);
    #1;
    checks++; if (got.size() != 20) $display("FAIL midreset partial plots: got %0d want 20", got.size()); else passed++;
    got.delete();
    build_exp(1'b1, 40, 40);
    start(1'b1, 1'b0, 40, 40);
    wait_done(1'b1, e);
    checks++; if (e !== 66) $display("FAIL midreset redraw latency: got edge %0d want 66", e); else passed++;
    d = plot_diff();
    checks++; if (d != -1) $display("FAIL midreset redraw plots: got %0d plots want %0d, first difference at %0d", got.size(), exp_q.size(), d); else passed++;
    drawBG = 1'b0;
    @(posedge clock); #1;
  endtask

  initial begin
    test_reset();
    test_bg_pass();
    test_char_pass();
    test_both_requests();
    test_clip_edge();
    test_park_position();
    test_reset_mid_draw();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
